// File: rtl/user_pulse_seq_pkg.sv
// Shared types and sizing for the user-domain pulse-train sequencer.
//   NumPhases  : number of phases played in index order
//   CntWidth   : width of period length / switch threshold / period counter
//   RepWidth   : width of per-phase repeat counts, loop count and their counters
//   state_t    : sequencer state, also exported on state_o
//   phase_cfg_t: one phase's shadowed configuration
package user_pulse_seq_pkg;

  localparam int NumPhases  = 4;
  localparam int CntWidth   = 16;
  localparam int RepWidth   = 8;
  localparam int PhaseWidth = (NumPhases > 1) ? $clog2(NumPhases) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CntWidth-1:0] end_cnt;
    logic [CntWidth-1:0] sw_cnt;
    logic [RepWidth-1:0] rep;
    logic                inv;
  } phase_cfg_t;

  // A phase only takes part in the sequence if it has at least one period
  // of at least one cycle; anything else is skipped without spending time.
  function automatic logic phase_active(input phase_cfg_t cfg);
    return (cfg.rep != '0) && (cfg.end_cnt != '0);
  endfunction

endpackage

// File: rtl/user_pulse_seq_if.sv
// Control/config/status bundle of the pulse sequencer.
//   start_i, stop_i            : run request / abort
//   phase_end_i, phase_switch_i: per-phase period length and high-time
//   phase_rep_i, phase_inv_i   : per-phase period count and polarity
//   loop_i                     : sequence repetitions, 0 = endless
//   pulse_o, busy_o, done_o    : pulse train, running flag, completion strobe
//   phase_o, state_o           : current phase index and state
// master drives config/commands, slave is the sequencer.
interface user_pulse_seq_if;
  import user_pulse_seq_pkg::*;

  logic                                start_i;
  logic                                stop_i;
  logic [NumPhases-1:0][CntWidth-1:0]  phase_end_i;
  logic [NumPhases-1:0][CntWidth-1:0]  phase_switch_i;
  logic [NumPhases-1:0][RepWidth-1:0]  phase_rep_i;
  logic [NumPhases-1:0]                phase_inv_i;
  logic [RepWidth-1:0]                 loop_i;
  logic                                pulse_o;
  logic                                busy_o;
  logic                                done_o;
  logic [PhaseWidth-1:0]               phase_o;
  state_t                              state_o;

  modport master (
    output start_i, stop_i, phase_end_i, phase_switch_i, phase_rep_i,
           phase_inv_i, loop_i,
    input  pulse_o, busy_o, done_o, phase_o, state_o
  );

  modport slave (
    input  start_i, stop_i, phase_end_i, phase_switch_i, phase_rep_i,
           phase_inv_i, loop_i,
    output pulse_o, busy_o, done_o, phase_o, state_o
  );

endinterface

// File: rtl/user_pulse_seq_next_phase.sv
// Combinational priority search over the active-phase mask.
//   active_i     : one bit per phase, 1 = phase takes part in the sequence
//   cur_i        : current phase index
//   first_idx_o  : lowest active index (valid when first_valid_o)
//   next_idx_o   : lowest active index strictly above cur_i (valid when next_valid_o)
module user_pulse_seq_next_phase
  import user_pulse_seq_pkg::*;
(
  input  logic [NumPhases-1:0]  active_i,
  input  logic [PhaseWidth-1:0] cur_i,
  output logic [PhaseWidth-1:0] first_idx_o,
  output logic                  first_valid_o,
  output logic [PhaseWidth-1:0] next_idx_o,
  output logic                  next_valid_o
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    first_idx_o   = '0;
    first_valid_o = 1'b0;
    next_idx_o    = '0;
    next_valid_o  = 1'b0;
    for (int i = NumPhases - 1; i >= 0; i--) begin
      if (active_i[i]) begin
        first_idx_o   = PhaseWidth'(i);
        first_valid_o = 1'b1;
        if (i > int'(cur_i)) begin
          next_idx_o   = PhaseWidth'(i);
          next_valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/user_pulse_seq.sv
// Multi-phase pulse-train sequencer.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : control/config/status bundle (slave side), see user_pulse_seq_if
// Config is captured into shadow registers on start, so software may
// reprogram the inputs while a sequence is playing.
//
// state | meaning
// IDLE  | waiting for start_i; outputs quiet
// RUN   | playing periods of the active phases; busy_o high
// DONE  | one cycle with done_o high after normal completion
module user_pulse_seq
  import user_pulse_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  user_pulse_seq_if.slave   bus
);

  state_t                         state_q, state_d;
  logic [PhaseWidth-1:0]          phase_q, phase_d;
  logic [CntWidth-1:0]            cnt_q, cnt_d;
  logic [RepWidth-1:0]            rep_q, rep_d;
  logic [RepWidth-1:0]            loop_q, loop_d;
  phase_cfg_t [NumPhases-1:0]     cfg_q, cfg_d;
  logic [RepWidth-1:0]            loop_cfg_q, loop_cfg_d;
  logic                           pulse_q, pulse_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  phase_cfg_t [NumPhases-1:0]     cfg_in;
  logic [NumPhases-1:0]           active;
  phase_cfg_t                     cur_cfg;
  phase_cfg_t                     nxt_cfg;
  logic [PhaseWidth-1:0]          first_idx, next_idx;
  logic                           first_valid, next_valid;
  logic                           period_end;
  logic [RepWidth-1:0]            rep_inc;
  logic [RepWidth-1:0]            loop_inc;

  always_comb begin
    for (int p = 0; p < NumPhases; p++) begin
      cfg_in[p] = '{end_cnt: bus.phase_end_i[p],
                    sw_cnt:  bus.phase_switch_i[p],
                    rep:     bus.phase_rep_i[p],
                    inv:     bus.phase_inv_i[p]};
    end
  end

  // In IDLE the search looks at the live inputs (they are about to be
  // shadowed); while running it must only ever see the frozen shadow.
  always_comb begin
    for (int p = 0; p < NumPhases; p++) begin
      active[p] = phase_active((state_q == IDLE) ? cfg_in[p] : cfg_q[p]);
    end
  end

  user_pulse_seq_next_phase u_next_phase (
    .active_i      (active),
    .cur_i         (phase_q),
    .first_idx_o   (first_idx),
    .first_valid_o (first_valid),
    .next_idx_o    (next_idx),
    .next_valid_o  (next_valid)
  );

  assign cur_cfg    = cfg_q[phase_q];
  assign period_end = (cnt_q == cur_cfg.end_cnt - 1'b1);
  assign rep_inc    = rep_q + 1'b1;
  assign loop_inc   = loop_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    loop_d     = loop_q;
    cfg_d      = cfg_q;
    loop_cfg_d = loop_cfg_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          cfg_d      = cfg_in;
          loop_cfg_d = bus.loop_i;
          cnt_d      = '0;
          rep_d      = '0;
          loop_d     = '0;
          if (first_valid) begin
            phase_d = first_idx;
            state_d = RUN;
          end else begin
            phase_d = '0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (period_end) begin
          cnt_d = '0;
          if (rep_inc == cur_cfg.rep) begin
            rep_d = '0;
            if (next_valid) begin
              phase_d = next_idx;
            end else if ((loop_cfg_q == '0) || (loop_inc < loop_cfg_q)) begin
              // Endless mode lets loop_q wrap; it is never compared then.
              loop_d  = loop_inc;
              phase_d = first_idx;
            end else begin
              loop_d  = '0;
              state_d = DONE;
            end
          end else begin
            rep_d = rep_inc;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.stop_i) begin
      state_d = IDLE;
      phase_d = '0;
      cnt_d   = '0;
      rep_d   = '0;
      loop_d  = '0;
    end
  end

  // Outputs are registered from next-state values so they line up with
  // state_q/cnt_q in the same cycle without a combinational output path.
  always_comb begin
    nxt_cfg = cfg_d[phase_d];
    pulse_d = (state_d == RUN) && ((cnt_d < nxt_cfg.sw_cnt) ^ nxt_cfg.inv);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      rep_q      <= '0;
      loop_q     <= '0;
      cfg_q      <= '0;
      loop_cfg_q <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      loop_q     <= loop_d;
      cfg_q      <= cfg_d;
      loop_cfg_q <= loop_cfg_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.pulse_o = pulse_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.phase_o = phase_q;
  assign bus.state_o = state_q;

endmodule
